// File: rtl/trig_engine.sv
// ---------------------------------------------------------------------------
// trig_engine
//   Multi-channel trigger engine. Each masked channel is qualified by a
//   level or edge condition; the AND of all masked channels is one event.
//   After a programmable number of events and a programmable delay the
//   engine emits a trigger pulse of programmable width, then either returns
//   to IDLE (one-shot) or re-arms after a holdoff (auto).
//
// Optional build macro:
//   TRIG_SYNC_EN - inserts a 2-flop synchroniser per channel ahead of the
//                  sample register (adds 2 edges of input latency).
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   sig_in          - monitored channels
//   cfg_mask/value/edge - per-channel match configuration
//   cfg_count/delay/width/holdoff/auto - sequencing configuration,
//                     latched into shadow registers when arm is accepted
//   arm, abort      - control requests (abort wins over arm)
//   trig_out        - registered trigger pulse
//   armed           - high while in ARMED
//   state           - current state encoding (IDLE=0 .. HOLDOFF=4)
//   event_cnt       - events counted in the current arm cycle
//   fired_cnt       - total triggers fired, saturating
// ---------------------------------------------------------------------------
module trig_engine #(
    parameter int CH    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    sig_in,
    input  logic [CH-1:0]    cfg_mask,
    input  logic [CH-1:0]    cfg_value,
    input  logic [CH-1:0]    cfg_edge,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_holdoff,
    input  logic             cfg_auto,
    input  logic             arm,
    input  logic             abort,
    output logic             trig_out,
    output logic             armed,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] event_cnt,
    output logic [CNT_W-1:0] fired_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_FIRE    = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    // Input path: optional synchroniser feeding the sample register.
    logic [CH-1:0] s_in;
`ifdef TRIG_SYNC_EN
    logic [CH-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end
    assign s_in = sync2_q;
`else
    assign s_in = sig_in;
`endif

    logic [CH-1:0]    s_q, p_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;            // shared delay/width/holdoff counter
    logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
    logic [CNT_W-1:0] fired_cnt_q, fired_cnt_d;
    logic             trig_q, trig_d;
    logic [CH-1:0]    sh_mask_q, sh_mask_d, sh_value_q, sh_value_d, sh_edge_q, sh_edge_d;
    logic [CNT_W-1:0] sh_count_q, sh_count_d, sh_delay_q, sh_delay_d;
    logic [CNT_W-1:0] sh_width_q, sh_width_d, sh_holdoff_q, sh_holdoff_d;
    logic             sh_auto_q, sh_auto_d;

    // Match qualification runs on shadow config only.
    logic [CH-1:0]    sat;
    logic             match;
    logic [CNT_W-1:0] count_eff, width_eff;
    logic [CNT_W:0]   ev_next;
    logic             enter_fire;

    assign sat       = ~(s_q ^ sh_value_q) & (~sh_edge_q | (p_q ^ s_q));
    // An empty mask must never match, so the reduction-AND is gated by |mask.
    assign match     = (|sh_mask_q) && (&(sat | ~sh_mask_q));
    assign count_eff = (sh_count_q == '0) ? ONE : sh_count_q;
    assign width_eff = (sh_width_q == '0) ? ONE : sh_width_q;
    assign ev_next   = {1'b0, event_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        event_cnt_d  = event_cnt_q;
        fired_cnt_d  = fired_cnt_q;
        sh_mask_d    = sh_mask_q;
        sh_value_d   = sh_value_q;
        sh_edge_d    = sh_edge_q;
        sh_count_d   = sh_count_q;
        sh_delay_d   = sh_delay_q;
        sh_width_d   = sh_width_q;
        sh_holdoff_d = sh_holdoff_q;
        sh_auto_d    = sh_auto_q;
        enter_fire   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d      = ST_ARMED;
                        event_cnt_d  = '0;
                        sh_mask_d    = cfg_mask;
                        sh_value_d   = cfg_value;
                        sh_edge_d    = cfg_edge;
                        sh_count_d   = cfg_count;
                        sh_delay_d   = cfg_delay;
                        sh_width_d   = cfg_width;
                        sh_holdoff_d = cfg_holdoff;
                        sh_auto_d    = cfg_auto;
                    end
                end
                ST_ARMED: begin
                    if (match) begin
                        event_cnt_d = ev_next[CNT_W-1:0];
                        if (ev_next >= {1'b0, count_eff}) begin
                            if (sh_delay_q == '0) begin
                                enter_fire = 1'b1;
                            end else begin
                                state_d = ST_DELAY;
                                cnt_d   = sh_delay_q;
                            end
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q <= ONE) enter_fire = 1'b1;
                    else              cnt_d = cnt_q - ONE;
                end
                ST_FIRE: begin
                    if (cnt_q <= ONE) begin
                        if (!sh_auto_q) begin
                            state_d = ST_IDLE;
                        end else if (sh_holdoff_q == '0) begin
                            state_d     = ST_ARMED;
                            event_cnt_d = '0;
                        end else begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = sh_holdoff_q;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q <= ONE) begin
                        state_d     = ST_ARMED;
                        event_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (enter_fire) begin
                state_d = ST_FIRE;
                cnt_d   = width_eff;
                if (fired_cnt_q != ALL_ONES) fired_cnt_d = fired_cnt_q + ONE;
            end
        end

        // Registered pulse: high exactly while the next state is FIRE.
        trig_d = (state_d == ST_FIRE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q          <= '0;
            p_q          <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            event_cnt_q  <= '0;
            fired_cnt_q  <= '0;
            trig_q       <= 1'b0;
            sh_mask_q    <= '0;
            sh_value_q   <= '0;
            sh_edge_q    <= '0;
            sh_count_q   <= '0;
            sh_delay_q   <= '0;
            sh_width_q   <= '0;
            sh_holdoff_q <= '0;
            sh_auto_q    <= 1'b0;
        end else begin
            s_q          <= s_in;
            p_q          <= s_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            event_cnt_q  <= event_cnt_d;
            fired_cnt_q  <= fired_cnt_d;
            trig_q       <= trig_d;
            sh_mask_q    <= sh_mask_d;
            sh_value_q   <= sh_value_d;
            sh_edge_q    <= sh_edge_d;
            sh_count_q   <= sh_count_d;
            sh_delay_q   <= sh_delay_d;
            sh_width_q   <= sh_width_d;
            sh_holdoff_q <= sh_holdoff_d;
            sh_auto_q    <= sh_auto_d;
        end
    end

    assign trig_out  = trig_q;
    assign armed     = (state_q == ST_ARMED);
    assign state     = state_q;
    assign event_cnt = event_cnt_q;
    assign fired_cnt = fired_cnt_q;

endmodule

// File: tb/tb_trig_engine.sv
// ---------------------------------------------------------------------------
// tb_trig_engine
//   Directed bench for trig_engine (CH=8, CNT_W=8). Inputs are driven and
//   outputs sampled 1 time unit after each rising edge. SL is the extra
//   input latency added by the optional synchroniser.
// ---------------------------------------------------------------------------
module tb_trig_engine;

    localparam int CH    = 8;
    localparam int CNT_W = 8;
`ifdef TRIG_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic             clk;
    logic             rst;
    logic [CH-1:0]    sig_in;
    logic [CH-1:0]    cfg_mask, cfg_value, cfg_edge;
    logic [CNT_W-1:0] cfg_count, cfg_delay, cfg_width, cfg_holdoff;
    logic             cfg_auto, arm, abort;
    logic             trig_out, armed;
    logic [2:0]       state;
    logic [CNT_W-1:0] event_cnt, fired_cnt;

    int checks = 0;
    int errors = 0;
    logic seen;

    trig_engine #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .cfg_mask   (cfg_mask),
        .cfg_value  (cfg_value),
        .cfg_edge   (cfg_edge),
        .cfg_count  (cfg_count),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_holdoff(cfg_holdoff),
        .cfg_auto   (cfg_auto),
        .arm        (arm),
        .abort      (abort),
        .trig_out   (trig_out),
        .armed      (armed),
        .state      (state),
        .event_cnt  (event_cnt),
        .fired_cnt  (fired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sig_in = '0; arm = 1'b0; abort = 1'b0;
        cfg_mask = '0; cfg_value = '0; cfg_edge = '0;
        cfg_count = '0; cfg_delay = '0; cfg_width = '0; cfg_holdoff = '0; cfg_auto = 1'b0;
        step_n(2);
        rst = 1'b0;
        check("rst_state", 32'(state), 0);
        check("rst_trig", 32'(trig_out), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_event", 32'(event_cnt), 0);
        check("rst_fired", 32'(fired_cnt), 0);

        // Level one-shot, width 3
        cfg_mask = 8'h01; cfg_value = 8'h01; cfg_edge = 8'h00;
        cfg_count = 8'd1; cfg_delay = 8'd0; cfg_width = 8'd3; cfg_auto = 1'b0;
        do_arm();
        check("t1_armed", 32'(armed), 1);
        check("t1_state_armed", 32'(state), 1);
        sig_in = 8'h01;
        step_n(1 + SL);                       // edge E
        check("t1_trig_at_E", 32'(trig_out), 0);
        step();                               // E+1
        check("t1_trig_E1", 32'(trig_out), 1);
        check("t1_state_fire", 32'(state), 3);
        check("t1_fired", 32'(fired_cnt), 1);
        check("t1_event", 32'(event_cnt), 1);
        step();
        check("t1_trig_E2", 32'(trig_out), 1);
        step();
        check("t1_trig_E3", 32'(trig_out), 1);
        step();
        check("t1_trig_E4", 32'(trig_out), 0);
        check("t1_state_idle", 32'(state), 0);
        sig_in = 8'h00;
        step_n(3);

        // Edge count 4 + delay 5 on bit 7
        cfg_mask = 8'h80; cfg_value = 8'h80; cfg_edge = 8'h80;
        cfg_count = 8'd4; cfg_delay = 8'd5; cfg_width = 8'd1;
        do_arm();
        for (int k = 0; k < 4; k++) begin
            sig_in = 8'h80; step();
            sig_in = 8'h00; step();
        end
        step_n(SL);                           // now at E+1
        check("t2_event", 32'(event_cnt), 4);
        check("t2_state_delay", 32'(state), 2);
        step_n(4);                            // E+5
        check("t2_trig_E5", 32'(trig_out), 0);
        step();                               // E+6
        check("t2_trig_E6", 32'(trig_out), 1);
        check("t2_fired", 32'(fired_cnt), 2);
        step();
        check("t2_trig_E7", 32'(trig_out), 0);
        check("t2_state_idle", 32'(state), 0);

        // Multi-channel AND
        cfg_mask = 8'h0C; cfg_value = 8'h04; cfg_edge = 8'h00;
        cfg_count = 8'd1; cfg_delay = 8'd0; cfg_width = 8'd1;
        sig_in = 8'h0C;
        do_arm();
        step_n(3 + SL);
        check("t3_nomatch_trig", 32'(trig_out), 0);
        check("t3_nomatch_state", 32'(state), 1);
        check("t3_nomatch_event", 32'(event_cnt), 0);
        sig_in = 8'h04;
        step_n(1 + SL);
        check("t3_trig_at_E", 32'(trig_out), 0);
        step();
        check("t3_trig_E1", 32'(trig_out), 1);
        check("t3_fired", 32'(fired_cnt), 3);
        step();
        check("t3_state_idle", 32'(state), 0);

        // Empty mask never fires
        cfg_mask = 8'h00; cfg_value = 8'h00; sig_in = 8'h00;
        do_arm();
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            seen = seen | trig_out;
        end
        check("t3_mask0_seen", 32'(seen), 0);
        check("t3_mask0_state", 32'(state), 1);
        check("t3_mask0_event", 32'(event_cnt), 0);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_armed_state", 32'(state), 0);
        arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
        check("arm_abort_state", 32'(state), 0);

        // Auto re-arm with holdoff 10, width 2
        cfg_mask = 8'h01; cfg_value = 8'h01; cfg_edge = 8'h00;
        cfg_count = 8'd1; cfg_delay = 8'd0; cfg_width = 8'd2; cfg_holdoff = 8'd10; cfg_auto = 1'b1;
        sig_in = 8'h01;
        step_n(2 + SL);
        do_arm();                             // edge A
        step();                               // A+1
        check("t4_trig_A1", 32'(trig_out), 1);
        check("t4_fired_1", 32'(fired_cnt), 4);
        step();
        check("t4_trig_A2", 32'(trig_out), 1);
        step();                               // A+3
        check("t4_trig_A3", 32'(trig_out), 0);
        check("t4_state_holdoff", 32'(state), 4);
        step_n(10);                           // A+13
        check("t4_state_rearmed", 32'(state), 1);
        check("t4_trig_A13", 32'(trig_out), 0);
        step();                               // A+14
        check("t4_trig_A14", 32'(trig_out), 1);
        check("t4_fired_2", 32'(fired_cnt), 5);
        step_n(13);                           // A+27
        check("t4_trig_A27", 32'(trig_out), 1);
        check("t4_fired_3", 32'(fired_cnt), 6);
        abort = 1'b1; step(); abort = 1'b0;   // abort during FIRE
        check("t5_abort_fire_trig", 32'(trig_out), 0);
        check("t5_abort_fire_state", 32'(state), 0);
        check("t5_abort_event_kept", 32'(event_cnt), 1);
        check("t5_abort_fired_kept", 32'(fired_cnt), 6);

        // Abort during DELAY
        cfg_delay = 8'd5; cfg_width = 8'd1; cfg_holdoff = 8'd0; cfg_auto = 1'b0;
        do_arm();
        step();
        check("t5_state_delay", 32'(state), 2);
        step_n(2);
        abort = 1'b1; step(); abort = 1'b0;
        check("t5_abort_delay_state", 32'(state), 0);
        seen = trig_out;
        for (int k = 0; k < 8; k++) begin
            step();
            seen = seen | trig_out;
        end
        check("t5_abort_delay_seen", 32'(seen), 0);
        check("t5_abort_delay_fired", 32'(fired_cnt), 6);

        // Reset mid-FIRE
        cfg_delay = 8'd0; cfg_width = 8'd5;
        do_arm();
        step();
        check("t5_fire_before_rst", 32'(trig_out), 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("t5_rst_trig", 32'(trig_out), 0);
        check("t5_rst_state", 32'(state), 0);
        check("t5_rst_fired", 32'(fired_cnt), 0);
        check("t5_rst_event", 32'(event_cnt), 0);
        check("t5_rst_armed", 32'(armed), 0);

        // Config isolation and arm-while-armed
        sig_in = 8'h00;
        cfg_mask = 8'h01; cfg_value = 8'h01; cfg_edge = 8'h01;
        cfg_count = 8'd2; cfg_delay = 8'd0; cfg_width = 8'd1; cfg_auto = 1'b0;
        step_n(2 + SL);
        do_arm();
        cfg_count = 8'd7;
        sig_in = 8'h01; step();
        sig_in = 8'h00; step();
        step_n(SL);
        check("t6_event_1", 32'(event_cnt), 1);
        do_arm();                             // ignored outside IDLE
        check("t6_rearm_event", 32'(event_cnt), 1);
        check("t6_rearm_state", 32'(state), 1);
        sig_in = 8'h01; step();
        sig_in = 8'h00; step();
        step_n(SL);
        check("t6_trig", 32'(trig_out), 1);
        check("t6_event_2", 32'(event_cnt), 2);
        check("t6_fired", 32'(fired_cnt), 1);
        step();
        check("t6_state_idle", 32'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
